// File: rtl/cb_config_loader_if.sv
// Word-stream configuration bus between the fabric config controller and a loader.
// The master drives words; the slave (loader) returns cfg_ready.
interface cb_config_loader_if #(
    parameter int DIN_W = 8
) ();
    logic             cfg_valid;
    logic             cfg_ready;
    logic [DIN_W-1:0] cfg_data;
    logic             cfg_last;

    modport master (
        output cfg_valid,
        output cfg_data,
        output cfg_last,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_data,
        input  cfg_last,
        output cfg_ready
    );
endinterface

// File: rtl/cb_config_loader.sv
// Loads a connection_block configuration vector from a narrow word stream into a
// shadow register and publishes it to c atomically once a well-framed load completes.
module cb_config_loader #(
    parameter int CFG_W = 44,
    parameter int DIN_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                abort,
    cb_config_loader_if.slave   cfg,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [CFG_W-1:0]    c
);
    localparam int NWORDS = (CFG_W + DIN_W - 1) / DIN_W;
    localparam int IDX_W  = $clog2(NWORDS + 1);
    localparam int POS_W  = $clog2(CFG_W);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWORDS - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        COMMIT = 2'd2,
        ERR    = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [CFG_W-1:0]   shadow_q, shadow_d;
    logic [CFG_W-1:0]   c_q, c_d;
    logic               done_q, done_d;
    logic               cfg_ready_s;

    // Places word w at slot i of the shadow; bits landing at or above CFG_W are dropped.
    function automatic logic [CFG_W-1:0] insert_word(
        input logic [CFG_W-1:0] sh,
        input logic [IDX_W-1:0] i,
        input logic [DIN_W-1:0] w
    );
        logic [CFG_W-1:0] r;
        int               pos;
        r = sh;
        for (int b = 0; b < DIN_W; b++) begin
            pos = int'(i) * DIN_W + b;
            if (pos < CFG_W) begin
                r[pos[POS_W-1:0]] = w[b];
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

    // Next-state, shadow accumulation and commit logic.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        shadow_d    = shadow_q;
        c_d         = c_q;
        done_d      = 1'b0;
        cfg_ready_s = 1'b0;
        case (state_q)
            IDLE, ERR: begin
                if (start) begin
                    state_d  = LOAD;
                    idx_d    = {IDX_W{1'b0}};
                    shadow_d = {CFG_W{1'b0}};
                end else begin
                    state_d  = state_q;
                end
            end
            LOAD: begin
                // abort wins over a word offered in the same cycle
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    cfg_ready_s = 1'b1;
                    if (cfg.cfg_valid) begin
                        shadow_d = insert_word(shadow_q, idx_q, cfg.cfg_data);
                        idx_d    = idx_q + IDX_ONE;
                        if (idx_q == LAST_IDX) begin
                            state_d = cfg.cfg_last ? COMMIT : ERR;
                        end else if (cfg.cfg_last) begin
                            state_d = ERR;
                        end else begin
                            state_d = LOAD;
                        end
                    end else begin
                        state_d = LOAD;
                    end
                end
            end
            COMMIT: begin
                c_d     = shadow_q;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, shadow and active configuration registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            idx_q    <= {IDX_W{1'b0}};
            shadow_q <= {CFG_W{1'b0}};
            c_q      <= {CFG_W{1'b0}};
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            shadow_q <= shadow_d;
            c_q      <= c_d;
            done_q   <= done_d;
        end
    end

    assign cfg.cfg_ready = cfg_ready_s;
    assign busy          = (state_q == LOAD) || (state_q == COMMIT);
    assign err           = (state_q == ERR);
    assign done          = done_q;
    assign c             = c_q;
endmodule

// File: doc/cb_config_loader.md
Name: cb_config_loader

Overview:
- Loads the wide configuration vector `c` of one unidirectional connection_block from a narrow word stream using a valid/ready handshake.
- Words accumulate in a shadow register. The active `c` updates atomically only when a complete, correctly framed load finishes.
- Sits between the fabric configuration bus and each connection_block instance. It drives the block's `c` port directly.

Parameters:
- CFG_W, 44, width of the connection_block `c` vector (default tile: SEL_PER_OUT*2*(CLBOS+CLBOD) + SEL_PER_IN0*CLBIN0 + SEL_PER_IN1*CLBIN1).
- DIN_W, 8, configuration word width.
- NWORDS, (CFG_W+DIN_W-1)/DIN_W (6 at defaults), derived local value: words per load.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin a load; honoured only in IDLE or ERR.
- abort  in  1  abandon the current load; honoured only in LOAD.
- cfg_valid  in  1  word valid.
- cfg_ready  out  1  loader can accept a word.
- cfg_data  in  DIN_W  configuration word, least-significant word first.
- cfg_last  in  1  marks the final word of a load.
- busy  out  1  high in LOAD and COMMIT.
- done  out  1  one-cycle pulse when `c` has been updated.
- err  out  1  framing error; held high until the next start.
- c  out  CFG_W  active configuration to connection_block.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; c=0 (all muxes select pass-through/default routing).
  - shadow=0, word index idx=0.
  - cfg_ready=0, busy=0, done=0, err=0.
- States: IDLE, LOAD, COMMIT, ERR.
- IDLE:
  - start=1 -> LOAD; idx cleared to 0, shadow cleared to 0.
  - cfg_valid is ignored.
- LOAD:
  - cfg_ready=1 (registered or combinational from state; no dependence on cfg_valid).
  - A transfer occurs on an edge where cfg_valid & cfg_ready.
  - On transfer: shadow[idx*DIN_W +: DIN_W] <= cfg_data, with bits at or above CFG_W discarded in the final word; idx <= idx+1.
  - Transfer with cfg_last=1 and idx==NWORDS-1 -> COMMIT.
  - Transfer with cfg_last=1 and idx<NWORDS-1 -> ERR (short load).
  - Transfer with cfg_last=0 and idx==NWORDS-1 -> ERR (long load); the word is still written to shadow, which is discarded anyway.
  - abort=1 -> IDLE, with no transfer that cycle (cfg_ready is forced low when abort=1). c is unchanged.
  - abort has priority over a simultaneous transfer.
  - start while in LOAD is ignored.
- COMMIT, lasting exactly one cycle:
  - On the exiting edge: c <= shadow, done <= 1, next state IDLE.
  - done is high for exactly the one cycle after that edge, coincident with the first cycle of the new c.
  - cfg_ready=0 during COMMIT.
- ERR:
  - err=1, cfg_ready=0, c retains its prior value.
  - start=1 -> LOAD and clears err on the same edge.
- Latency: final handshake at edge E0 -> COMMIT; at E1, c is new and done=1; done falls at E2.
- c never changes except at a COMMIT exit edge or on reset. No partial configuration is ever visible.
- A reset asserted mid-load returns everything to reset values immediately, independent of clk.
- idx needs $clog2(NWORDS+1) bits and must not wrap in a way that permits a 7th write at defaults.

Test Plan:
- Reset: rst_n=0 asynchronously mid-cycle -> c=44'h0, cfg_ready=0, busy=0, done=0, err=0 before the next clk edge.
- Good load: start, then words 8'h01..8'h06 back-to-back with cfg_last on the 6th -> c=44'h60504030201 one edge after COMMIT, done high for exactly 1 cycle, busy low afterwards.
- Backpressure/gaps: same words with cfg_valid deasserted for 3 cycles between words 2 and 3 and with cfg_data changing while cfg_valid=0 -> identical c=44'h60504030201, no extra writes.
- Short load: after a good load, start, then 3 words with cfg_last on the 3rd -> err=1, done never pulses, c stays 44'h60504030201. A following start clears err.
- Long load: 6 words with cfg_last=0 -> err=1 on the edge after the 6th handshake, c unchanged, cfg_ready=0 until start.
- Abort and reset mid-load:
  - abort after 4 words, with cfg_valid=1 the same cycle -> IDLE, no transfer, c unchanged. A new full load of 8'hFF words then yields c=44'hFFFFFFFFFFF.
  - rst_n pulsed after 2 words -> c=0 and state IDLE.
